present80_enc_ctrl: RTL and testbench

// - Sequences one PRESENT-80 encryption from the Wishbone key/plaintext/control registers: latches operands, runs 31 rounds plus a final key whitening, publishes ciphertext and status.
// - Sits between the WB register file outputs (key_out, plain_out, control word) and WB readback/IRQ; one round per clock, iterative.

---
 rtl/present80_pkg.sv | 32 +++
 rtl/present80_enc_ctrl_if.sv | 27 ++
 rtl/present80_round.sv | 38 +++
 rtl/present80_enc_ctrl.sv | 147 ++++++++++++++
 tb/tb_present80_enc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/present80_pkg.sv
// Shared definitions for the PRESENT-80 encryption controller: S-box table,
// pLayer bit permutation, FSM state encoding and control-word bit positions.
package present80_pkg;

  // PRESENT 4-bit S-box, indexed by the input nibble.
  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Control word bit positions (key[79:64] occupies ctrl[31:16]).
  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int CTRL_STEP_MODE = 2;
  localparam int CTRL_STEP      = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } fsm_state_e;

  // pLayer destination of bit i: (16*i) mod 63, with bit 63 fixed.
  // Because 64 == 1 (mod 63), multiplying a 6-bit index by 16 is a
  // 4-bit left rotation, which also maps 63 onto itself.
  function automatic logic [5:0] player(input logic [5:0] i);
    return {i[1:0], i[5:2]};
  endfunction

endpackage

// File: rtl/present80_enc_ctrl_if.sv
// Register-file side bus of the PRESENT-80 controller.
// master = Wishbone register file (drives operands/control, reads result)
// slave  = encryption controller.
// Protocol: there is no valid/ready pair. A job is requested by a rising edge
// of ctrl_i[0]; ctrl_i[1] high aborts a job in LOAD/ROUND. Completion is
// signalled by irq_o (one cycle) and the sticky done_o, with cipher_o valid
// while done_o is high.
interface present80_enc_ctrl_if;
  logic [63:0] key_i;
  logic [63:0] plain_i;
  logic [31:0] ctrl_i;
  logic [63:0] cipher_o;
  logic [31:0] status_o;
  logic        busy_o;
  logic        done_o;
  logic        irq_o;

  modport master (
    output key_i, plain_i, ctrl_i,
    input  cipher_o, status_o, busy_o, done_o, irq_o
  );

  modport slave (
    input  key_i, plain_i, ctrl_i,
    output cipher_o, status_o, busy_o, done_o, irq_o
  );
endinterface

// File: rtl/present80_round.sv
// One combinational PRESENT-80 round: addRoundKey, sBoxLayer, pLayer, plus
// the key-schedule update for round counter rc.
module present80_round
  import present80_pkg::*;
(
  input  logic [63:0] state,
  input  logic [79:0] key,
  input  logic [4:0]  rc,
  output logic [63:0] next_state,
  output logic [79:0] next_key
);

  logic [63:0] mixed;
  logic [63:0] subbed;
  logic [79:0] rotated;

  // Data path: round key addition, nibble substitution, bit permutation.
  always_comb begin
    mixed  = state ^ key[79:16];
    subbed = '0;
    for (int n = 0; n < 16; n++) begin
      subbed[4*n +: 4] = SBOX[mixed[4*n +: 4]];
    end
    next_state = '0;
    for (int b = 0; b < 64; b++) begin
      next_state[player(6'(b))] = subbed[b];
    end
  end

  // Key schedule: rotate left 61, S-box the top nibble, fold in rc.
  always_comb begin
    rotated         = {key[18:0], key[79:19]};
    next_key        = rotated;
    next_key[79:76] = SBOX[rotated[79:76]];
    next_key[19:15] = rotated[19:15] ^ rc;
  end

endmodule

// File: rtl/present80_enc_ctrl.sv
// PRESENT-80 encryption sequencer: one round per clock, 31 rounds followed by
// final key whitening. Optional feature macro: PRESENT80_STEP_EN (single-step
// rounds on rising edges of ctrl_i[3] while ctrl_i[2] is set).
module present80_enc_ctrl
  import present80_pkg::*;
#(
  parameter int ROUNDS = 31,
  parameter int BLK_W  = 64,
  parameter int KEY_W  = 80
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  present80_enc_ctrl_if.slave  bus,
  output fsm_state_e           dbg_state
);

  localparam logic [4:0] LAST_RC = 5'(ROUNDS);

  fsm_state_e       fsm_q;
  logic [BLK_W-1:0] state_q;
  logic [BLK_W-1:0] cipher_q;
  logic [KEY_W-1:0] key_q;
  logic [4:0]       rc_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             irq_q;
  logic             start_q;
  logic             start_edge;
  logic             abort;
  logic             advance;
  logic [BLK_W-1:0] rnd_state;
  logic [KEY_W-1:0] rnd_key;
  logic [4:0]       rnd;

  assign start_edge = bus.ctrl_i[CTRL_START] & ~start_q;
  assign abort      = bus.ctrl_i[CTRL_ABORT];

`ifdef PRESENT80_STEP_EN
  logic step_q;
  logic unused_ctrl;

  // History of the step bit for rising-edge detection.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) step_q <= 1'b0;
    else            step_q <= bus.ctrl_i[CTRL_STEP];
  end

  assign advance     = ~bus.ctrl_i[CTRL_STEP_MODE] | (bus.ctrl_i[CTRL_STEP] & ~step_q);
  assign unused_ctrl = ^bus.ctrl_i[15:4];
`else
  logic unused_ctrl;

  assign advance     = 1'b1;
  assign unused_ctrl = ^bus.ctrl_i[15:2];
`endif

  present80_round u_round (
    .state      (state_q),
    .key        (key_q),
    .rc         (rc_q),
    .next_state (rnd_state),
    .next_key   (rnd_key)
  );

  // Sequencer: operand latch, round iteration, result publish, status flags.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      key_q    <= '0;
      cipher_q <= '0;
      rc_q     <= 5'd1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= bus.ctrl_i[CTRL_START];
      irq_q   <= 1'b0;
      // A new request while a job is in flight is dropped but flagged.
      if (start_edge && fsm_q != IDLE) err_q <= 1'b1;
      case (fsm_q)
        IDLE: begin
          rc_q <= 5'd1;
          if (start_edge && !abort) begin
            fsm_q  <= LOAD;
            busy_q <= 1'b1;
          end
        end
        LOAD: begin
          rc_q <= 5'd1;
          if (abort) begin
            fsm_q  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else begin
            state_q <= bus.plain_i;
            key_q   <= {bus.ctrl_i[31:16], bus.key_i};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          if (abort) begin
            fsm_q  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rc_q   <= 5'd1;
          end else if (advance) begin
            state_q <= rnd_state;
            key_q   <= rnd_key;
            // rc stops at the last round so it never wraps.
            if (rc_q == LAST_RC) fsm_q <= FINAL;
            else                 rc_q  <= rc_q + 5'd1;
          end
        end
        FINAL: begin
          cipher_q <= state_q ^ key_q[KEY_W-1 -: BLK_W];
          done_q   <= 1'b1;
          irq_q    <= 1'b1;
          fsm_q    <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          rc_q   <= 5'd1;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Round number is reported only while a job is active so that the idle
  // status word reads all zeros.
  assign rnd = busy_q ? rc_q : 5'd0;

  assign bus.cipher_o = cipher_q;
  assign bus.status_o = {24'b0, rnd, err_q, done_q, busy_q};
  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.irq_o    = irq_q;
  assign dbg_state    = fsm_q;

endmodule

// File: tb/tb_present80_enc_ctrl.sv
// Directed + randomized bench for present80_enc_ctrl with a behavioural
// PRESENT-80 reference model.
`timescale 1ns/1ps
module tb_present80_enc_ctrl;
  import present80_pkg::*;

  localparam int ROUNDS = 31;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  fsm_state_e dbg_state;

  present80_enc_ctrl_if bus();

  present80_enc_ctrl #(.ROUNDS(ROUNDS)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          cmp_cnt  = 0;
  int          fail_cnt = 0;
  int          irq_cnt  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_exp = '0;

  always @(negedge clk) if (rst_n && bus.irq_o) irq_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] ref_sbox [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] ref_enc(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= ROUNDS; r++) begin
      s = s ^ k[79:16];
      t = '0;
      for (int i = 0; i < 16; i++) t[4*i +: 4] = ref_sbox[s[4*i +: 4]];
      s = '0;
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
      k = {k[18:0], k[79:19]};
      k[79:76] = ref_sbox[k[79:76]];
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [79:0] rand80();
    return {16'($urandom_range(0, 65535)), $urandom(), $urandom()};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [79:0] k, input logic [63:0] p);
    bus.key_i          = k[63:0];
    bus.plain_i        = p;
    bus.ctrl_i[31:16]  = k[79:64];
  endtask

  // Returns just after the edge that samples the start edge (cycle 0).
  task automatic launch(input logic [79:0] k, input logic [63:0] p);
    set_ops(k, p);
    bus.ctrl_i[0] = 1'b0;
    tick();
    bus.ctrl_i[0] = 1'b1;
    tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done_o && n < 100);
  endtask

  task automatic wait_rnd(input string tag, input int r);
    int n;
    n = 0;
    while (bus.status_o[7:3] != 5'(r) && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_reach_round"}, 64'(bus.status_o[7:3]), 64'(r));
  endtask

  task automatic run_and_check(input string tag, input logic [79:0] k,
                               input logic [63:0] p, input bit scramble);
    int n;
    int off;
    int irq0;
    exp_q.push_back(ref_enc(k, p));
    irq0 = irq_cnt;
    off  = 0;
    launch(k, p);
    if (scramble) begin
      tick();
      set_ops(rand80(), rand64());
      off = 1;
    end
    wait_done(n);
    check({tag, "_latency"}, 64'(n + off), 64'(ROUNDS + 2));
    check({tag, "_irq"}, 64'(bus.irq_o), 64'd1);
    check({tag, "_status"}, 64'(bus.status_o[2:0]), 64'b011);
    last_exp = exp_q.pop_front();
    check({tag, "_cipher"}, bus.cipher_o, last_exp);
    tick();
    check({tag, "_irq_count"}, 64'(irq_cnt - irq0), 64'd1);
    check({tag, "_busy_end"}, 64'(bus.busy_o), 64'd0);
    bus.ctrl_i[0] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [79:0] k;
    logic [63:0] p;
    int          irq0;
    int          n;

    rst_n       = 1'b0;
    bus.key_i   = '0;
    bus.plain_i = '0;
    bus.ctrl_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cipher", bus.cipher_o, 64'd0);
    check("rst_status", 64'(bus.status_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_done", 64'(bus.done_o), 64'd0);
    check("rst_irq", 64'(bus.irq_o), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    tick();

    // Published test vectors.
    run_and_check("kv_zero", 80'd0, 64'd0, 1'b0);
    check("kv_zero_const", bus.cipher_o, 64'h5579C1387B228445);
    run_and_check("kv_key1", {80{1'b1}}, 64'd0, 1'b0);
    check("kv_key1_const", bus.cipher_o, 64'hE72C46C0F5945049);
    run_and_check("kv_pt1", 80'd0, {64{1'b1}}, 1'b0);
    check("kv_pt1_const", bus.cipher_o, 64'hA112FFC72F68417B);

    // All ones with start held high: exactly one job.
    set_ops({80{1'b1}}, {64{1'b1}});
    bus.ctrl_i[0] = 1'b0;
    tick();
    irq0 = irq_cnt;
    bus.ctrl_i[0] = 1'b1;
    repeat (100) tick();
    check("held_irq_count", 64'(irq_cnt - irq0), 64'd1);
    check("held_cipher", bus.cipher_o, 64'h3333DCD3213210D2);
    check("held_done", 64'(bus.done_o), 64'd1);
    check("held_busy", 64'(bus.busy_o), 64'd0);
    last_exp = 64'h3333DCD3213210D2;
    bus.ctrl_i[0] = 1'b0;
    tick();

    // Abort at round 10.
    irq0 = irq_cnt;
    launch(rand80(), rand64());
    wait_rnd("abort", 10);
    bus.ctrl_i[1] = 1'b1;
    tick();
    check("abort_busy", 64'(bus.busy_o), 64'd0);
    check("abort_done", 64'(bus.done_o), 64'd0);
    check("abort_cipher", bus.cipher_o, last_exp);
    check("abort_state", 64'(dbg_state), 64'(IDLE));
    bus.ctrl_i[1:0] = 2'b00;
    repeat (40) tick();
    check("abort_no_irq", 64'(irq_cnt - irq0), 64'd0);
    run_and_check("after_abort", rand80(), rand64(), 1'b0);

    // Abort and start edge together in IDLE: abort wins.
    bus.ctrl_i[1:0] = 2'b11;
    tick();
    check("abort_start_busy", 64'(bus.busy_o), 64'd0);
    tick();
    check("abort_start_state", 64'(dbg_state), 64'(IDLE));
    bus.ctrl_i[1:0] = 2'b00;
    tick();

    // Start edge during a run at round 5.
    k = rand80();
    p = rand64();
    exp_q.push_back(ref_enc(k, p));
    launch(k, p);
    wait_rnd("err", 5);
    bus.ctrl_i[0] = 1'b0;
    tick();
    bus.ctrl_i[0] = 1'b1;
    tick();
    check("err_flag", 64'(bus.status_o[2]), 64'd1);
    wait_done(n);
    last_exp = exp_q.pop_front();
    check("err_cipher", bus.cipher_o, last_exp);
    check("err_sticky", 64'(bus.status_o[2]), 64'd1);
    bus.ctrl_i[0] = 1'b0;
    repeat (2) tick();

    // Randomized jobs, operands changed after latching.
    for (int i = 0; i < 4; i++) begin
      run_and_check("rand", rand80(), rand64(), 1'b1);
    end

    // Reset mid-run at round 20.
    irq0 = irq_cnt;
    launch(rand80(), rand64());
    wait_rnd("midrst", 20);
    rst_n = 1'b0;
    #1;
    check("midrst_cipher", bus.cipher_o, 64'd0);
    check("midrst_status", 64'(bus.status_o), 64'd0);
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_done", 64'(bus.done_o), 64'd0);
    check("midrst_irq", 64'(bus.irq_o), 64'd0);
    bus.ctrl_i[0] = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("midrst_no_irq", 64'(irq_cnt - irq0), 64'd0);
    run_and_check("after_rst", rand80(), rand64(), 1'b0);

`ifdef PRESENT80_STEP_EN
    // Single-step mode: one round per rising edge of ctrl_i[3].
    bus.ctrl_i[2] = 1'b1;
    bus.ctrl_i[3] = 1'b0;
    launch(80'd0, 64'd0);
    tick();
    check("step_rnd_first", 64'(bus.status_o[7:3]), 64'd1);
    repeat (3) tick();
    check("step_hold", 64'(bus.status_o[7:3]), 64'd1);
    for (int i = 1; i <= ROUNDS; i++) begin
      bus.ctrl_i[3] = 1'b1;
      tick();
      bus.ctrl_i[3] = 1'b0;
      tick();
      check("step_rnd", 64'(bus.status_o[7:3]), 64'((i < ROUNDS) ? i + 1 : ROUNDS));
    end
    check("step_done", 64'(bus.done_o), 64'd1);
    check("step_cipher", bus.cipher_o, 64'h5579C1387B228445);
    bus.ctrl_i[3:0] = 4'b0000;
    repeat (2) tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
